// File: rtl/tt_um_uart_tx.sv
`default_nettype none
// ============================================================================
// tt_um_uart_tx : 8N1 UART transmitter in the TinyTapeout user-project shell
// Revision      : 1.0
// ============================================================================
module tt_um_uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int                 C_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [C_CNT_W-1:0] C_BAUD_LAST = C_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [C_CNT_W-1:0] C_BAUD_ONE  = C_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [C_CNT_W-1:0] baud_q, baud_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         shift_q, shift_d;
   logic               txd_q, txd_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               bit_end;
   logic               unused_in;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      bit_end = (baud_q == C_BAUD_LAST);

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + C_BAUD_ONE;
      end

      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (ena && uio_in[0]) begin
               shift_d = ui_in;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are derived from next state so they come straight off flops.
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign uo_out    = {5'b0_0000, done_q, busy_q, txd_q};
   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unused_in = &{1'b0, uio_in[7:1]};

endmodule
`default_nettype wire

// File: doc/tt_um_uart_tx.md
# tt_um_uart_tx

Byte-serial UART transmitter (8N1) that wraps into the standard TinyTapeout user-project port set. It latches a byte from `ui_in` on a start strobe and shifts it out LSB-first on `uo_out[0]` with start and stop framing. Status is reported on `uo_out[2:1]`. It is the transmit-side counterpart for designs whose input side is built from the project's Wokwi cell library. All bidirectional pins are left as inputs.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range 2..65535.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: design enable; gates acceptance of new frames only.
- `ui_in` input 8: transmit data byte.
- `uio_in` input 8: `uio_in[0]` is the start strobe; bits 7:1 are ignored.
- `uio_out` output 8: constant 0.
- `uio_oe` output 8: constant 0 (all pins are inputs).
- `uo_out` output 8: `[0]` txd, `[1]` busy, `[2]` done, `[7:3]` constant 0.

## Operation
- Reset values: txd=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE
  - txd=1, busy=0.
  - If `ena`=1 and `uio_in[0]`=1 at a clock edge, latch `ui_in` into the shift register and go to START.
  - The strobe is level-sampled; no edge detection.
- START
  - txd=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA
  - txd = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit counter.
  - After bit 7 completes, go to STOP.
- STOP
  - txd=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
  - Pulse done=1 for exactly one cycle, concurrent with entering IDLE.
- busy=1 in START, DATA and STOP.
- Any strobe while busy=1 is ignored; the data in flight is not disturbed.
- `ui_in` changes after the latch edge have no effect on the current frame.
- `ena` low mid-frame does not stall or abort the frame.
- Baud counter
  - Width is ceil(log2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Never exceeds CLKS_PER_BIT-1.
- txd, busy and done are driven directly from flops (glitch-free).

## Timing
- Strobe sampled at edge N: txd=0 and busy=1 are visible after edge N.
- Bit k (start=0, data 1..8, stop=9) occupies cycles N+k·CLKS_PER_BIT .. N+(k+1)·CLKS_PER_BIT-1.
- done=1 and busy=0 are visible after edge N+10·CLKS_PER_BIT.
- done stays high for one cycle only.
- Back-to-back frames: a strobe held high continuously is accepted at edge N+10·CLKS_PER_BIT+1.
  - Minimum frame spacing is therefore 10·CLKS_PER_BIT+1 cycles, with one idle-high cycle between frames.
- Strobe at the same edge where done is asserted: ignored, because the state machine is not yet IDLE at that edge.
- Reset asserted mid-frame: txd=1, busy=0, done=0 immediately, without waiting for a clock edge.
- After reset release, the first edge can accept a strobe.

## Test plan
- Reset check: CLKS_PER_BIT=4, hold `rst_n`=0.
  - Required: uo_out=8'h01, uio_oe=8'h00, uio_out=8'h00.
- Single frame: ui_in=8'hA5, one-cycle strobe.
  - txd per 4-cycle bit slot: 0,1,0,1,0,0,1,0,1,1.
  - busy high for exactly 40 cycles.
  - done high on cycle 40 only.
- Busy strobe: start 8'h3C, then strobe 8'hFF at cycle 10.
  - Frame still carries 0x3C: LSB-first data 0,0,1,1,1,1,0,0.
  - No second frame follows.
- Held strobe: hold strobe with ui_in=8'h00, then 8'hFF.
  - Two frames, with exactly 1 idle-high cycle between stop bit and next start bit.
- Enable gating: `ena`=0 with strobe high for 50 cycles.
  - txd stays 1, busy stays 0.
  - Then set `ena`=1: frame starts on the next edge.
- Reset mid-frame: assert `rst_n` during data bit 3.
  - txd=1 and busy=0 asynchronously.
  - After release, a new frame 8'h81 transmits correctly.
